// File: rtl/sc_reg_multimode_pkg.sv
// Shared op-code definitions for the multimode datapath register.
package sc_reg_multimode_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_SAR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_INC  = 3'b110;
    localparam logic [2:0] OP_DEC  = 3'b111;

endpackage

// File: rtl/sc_reg_multimode_if.sv
// Control/data bundle between the control unit (master) and the register (slave).
interface sc_reg_multimode_if #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int SHAMT_WIDTH   = $clog2(DATAWIDTH_BUS)
);
    logic                     SC_RegMULTIMODE_Clear_InHigh;
    logic                     SC_RegMULTIMODE_Write_InHigh;
    logic [2:0]               SC_RegMULTIMODE_Op_In;
    logic [SHAMT_WIDTH-1:0]   SC_RegMULTIMODE_ShiftAmt_In;
    logic [DATAWIDTH_BUS-1:0] SC_RegMULTIMODE_DataBUS_In;
    logic [DATAWIDTH_BUS-1:0] SC_RegMULTIMODE_DataBUS_Out;
    logic                     SC_RegMULTIMODE_Carry_Out;
    logic                     SC_RegMULTIMODE_Zero_Out;
    logic                     SC_RegMULTIMODE_Negative_Out;

    modport master (
        output SC_RegMULTIMODE_Clear_InHigh, SC_RegMULTIMODE_Write_InHigh,
               SC_RegMULTIMODE_Op_In, SC_RegMULTIMODE_ShiftAmt_In,
               SC_RegMULTIMODE_DataBUS_In,
        input  SC_RegMULTIMODE_DataBUS_Out, SC_RegMULTIMODE_Carry_Out,
               SC_RegMULTIMODE_Zero_Out, SC_RegMULTIMODE_Negative_Out
    );

    modport slave (
        input  SC_RegMULTIMODE_Clear_InHigh, SC_RegMULTIMODE_Write_InHigh,
               SC_RegMULTIMODE_Op_In, SC_RegMULTIMODE_ShiftAmt_In,
               SC_RegMULTIMODE_DataBUS_In,
        output SC_RegMULTIMODE_DataBUS_Out, SC_RegMULTIMODE_Carry_Out,
               SC_RegMULTIMODE_Zero_Out, SC_RegMULTIMODE_Negative_Out
    );
endinterface

// File: rtl/sc_reg_multimode_shifter.sv
// Combinational barrel shifter: next value and carry for SHL/SHR/SAR/ROL.
module sc_reg_multimode_shifter
    import sc_reg_multimode_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32,
    parameter int SHAMT_WIDTH   = $clog2(DATAWIDTH_BUS)
) (
    input  logic [2:0]               op,
    input  logic [SHAMT_WIDTH-1:0]   amt,
    input  logic [DATAWIDTH_BUS-1:0] value,
    input  logic                     carry_in,
    output logic [DATAWIDTH_BUS-1:0] value_next,
    output logic                     carry_next
);
    localparam int W = DATAWIDTH_BUS;

    int           n;
    int           k;
    logic [W-1:0] tmp;
    logic         msb;

    always_comb begin
        value_next = value;
        carry_next = carry_in;
        n          = int'(amt);
        k          = n % W;
        tmp        = '0;
        msb        = value[W-1];
        // A zero distance leaves both value and carry untouched for every shift op.
        if (n != 0) begin
            case (op)
                OP_SHL: begin
                    if (n >= W) begin
                        value_next = '0;
                        carry_next = 1'b0;
                    end else begin
                        value_next = value << n;
                        tmp        = value >> (W - n);
                        carry_next = tmp[0];
                    end
                end
                OP_SHR: begin
                    if (n >= W) begin
                        value_next = '0;
                        carry_next = 1'b0;
                    end else begin
                        value_next = value >> n;
                        tmp        = value >> (n - 1);
                        carry_next = tmp[0];
                    end
                end
                OP_SAR: begin
                    if (n >= W) begin
                        value_next = {W{msb}};
                        carry_next = msb;
                    end else begin
                        value_next = $signed(value) >>> n;
                        tmp        = value >> (n - 1);
                        carry_next = tmp[0];
                    end
                end
                OP_ROL: begin
                    if (k != 0) begin
                        value_next = (value << k) | (value >> (W - k));
                        carry_next = value_next[0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/sc_reg_multimode.sv
// Multimode datapath register: clear/load/shift/rotate/inc/dec, falling-edge capture.
module sc_reg_multimode
    import sc_reg_multimode_pkg::*;
#(
    parameter int                       DATAWIDTH_BUS = 32,
    parameter int                       SHAMT_WIDTH   = $clog2(DATAWIDTH_BUS),
    parameter logic [DATAWIDTH_BUS-1:0] RESET_VALUE   = '0
) (
    input logic               SC_RegMULTIMODE_CLOCK_50,
    input logic               SC_RegMULTIMODE_Reset_InHigh,
    sc_reg_multimode_if.slave bus
);
    localparam int W = DATAWIDTH_BUS;

    logic [W-1:0] r;
    logic [W-1:0] r_next;
    logic [W-1:0] sh_value;
    logic         c;
    logic         c_next;
    logic         sh_carry;
    logic [W:0]   inc_sum;
    logic [W:0]   dec_diff;

    sc_reg_multimode_shifter #(
        .DATAWIDTH_BUS(DATAWIDTH_BUS),
        .SHAMT_WIDTH  (SHAMT_WIDTH)
    ) u_shifter (
        .op        (bus.SC_RegMULTIMODE_Op_In),
        .amt       (bus.SC_RegMULTIMODE_ShiftAmt_In),
        .value     (r),
        .carry_in  (c),
        .value_next(sh_value),
        .carry_next(sh_carry)
    );

    // The extra top bit is the carry out of INC and the borrow out of DEC.
    assign inc_sum  = {1'b0, r} + (W + 1)'(1);
    assign dec_diff = {1'b0, r} - (W + 1)'(1);

    always_comb begin
        r_next = r;
        c_next = c;
        if (bus.SC_RegMULTIMODE_Clear_InHigh) begin
            r_next = RESET_VALUE;
            c_next = 1'b0;
        end else if (bus.SC_RegMULTIMODE_Write_InHigh) begin
            case (bus.SC_RegMULTIMODE_Op_In)
                OP_LOAD: begin
                    r_next = bus.SC_RegMULTIMODE_DataBUS_In;
                    c_next = 1'b0;
                end
                OP_SHL, OP_SHR, OP_SAR, OP_ROL: begin
                    r_next = sh_value;
                    c_next = sh_carry;
                end
                OP_INC: begin
                    r_next = inc_sum[W-1:0];
                    c_next = inc_sum[W];
                end
                OP_DEC: begin
                    r_next = dec_diff[W-1:0];
                    c_next = dec_diff[W];
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge SC_RegMULTIMODE_CLOCK_50 or posedge SC_RegMULTIMODE_Reset_InHigh) begin
        if (SC_RegMULTIMODE_Reset_InHigh) begin
            r <= RESET_VALUE;
            c <= 1'b0;
        end else begin
            r <= r_next;
            c <= c_next;
        end
    end

    assign bus.SC_RegMULTIMODE_DataBUS_Out  = r;
    assign bus.SC_RegMULTIMODE_Carry_Out    = c;
    assign bus.SC_RegMULTIMODE_Zero_Out     = (r == '0);
    assign bus.SC_RegMULTIMODE_Negative_Out = r[W-1];
endmodule

// File: doc/sc_reg_multimode.md
Name: sc_reg_multimode

Overview:
- Parametrised general-purpose datapath register, successor to the plain load/hold register.
- Adds a synchronous clear and in-place operations: parallel load, logical/arithmetic shifts, rotate, increment and decrement.
- Provides a registered carry flag and combinational zero/negative flags.
- Sits in the uDataPath register bank; the control unit drives the op code, the bus and ALU consume the output and flags.

Parameters:
- DATAWIDTH_BUS, 32, register and data bus width (≥2).
- SHAMT_WIDTH, $clog2(DATAWIDTH_BUS), width of the shift-amount port.
- RESET_VALUE, 0, value loaded by reset and by clear.

Ports:
- SC_RegMULTIMODE_CLOCK_50  in  1  single clock; register captures on the falling edge, as the rest of the datapath does.
- SC_RegMULTIMODE_Reset_InHigh  in  1  asynchronous, active-high reset.
- SC_RegMULTIMODE_Clear_InHigh  in  1  synchronous clear to RESET_VALUE.
- SC_RegMULTIMODE_Write_InHigh  in  1  enables the operation selected by Op_In.
- SC_RegMULTIMODE_Op_In  in  3  operation select.
- SC_RegMULTIMODE_ShiftAmt_In  in  SHAMT_WIDTH  shift/rotate distance.
- SC_RegMULTIMODE_DataBUS_In  in  DATAWIDTH_BUS  parallel load data.
- SC_RegMULTIMODE_DataBUS_Out  out  DATAWIDTH_BUS  register contents.
- SC_RegMULTIMODE_Carry_Out  out  1  registered carry/borrow/shifted-out bit.
- SC_RegMULTIMODE_Zero_Out  out  1  combinational: contents == 0.
- SC_RegMULTIMODE_Negative_Out  out  1  combinational: contents MSB.

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- Reset: R = RESET_VALUE, C = 0, immediately and independent of clock. Outputs follow R, so Zero_Out and Negative_Out derive from RESET_VALUE. Reset asserted mid-operation aborts that update.
- Update on each falling edge, in priority order: Clear > Write > hold.
  - Clear=1: R = RESET_VALUE, C = 0, regardless of Write and Op.
  - Write=0: R and C hold. Op, ShiftAmt and Data are ignored.
- Write=1, Op_In encoding (n = ShiftAmt_In, W = DATAWIDTH_BUS):
  - 000 HOLD: R, C unchanged.
  - 001 LOAD: R = DataBUS_In, C = 0.
  - 010 SHL: R = R << n (zero fill). C = R[W-n] (last bit out).
  - 011 SHR: R = R >> n (zero fill). C = R[n-1].
  - 100 SAR: R = R >>> n (sign fill). C = R[n-1].
  - 101 ROL: rotate left by (n mod W). C = new R[0]. C unchanged when n mod W = 0.
  - 110 INC: {C, R} = R + 1. At R = all-ones: R = 0, C = 1.
  - 111 DEC: R = R - 1; C = borrow (1 only when R was 0). At R = 0: R = all-ones, C = 1.
- Shift boundaries:
  - n = 0 for SHL/SHR/SAR/ROL: R and C unchanged.
  - n ≥ W (non-power-of-two W only): SHL/SHR give R = 0, C = 0; SAR gives R = all copies of the MSB, C = MSB.
- Latency: one falling edge from operands to R/C. Zero_Out and Negative_Out are combinational from R, zero added latency.
- Output updates are visible the same half-cycle after the falling edge. No output glitches from input changes; outputs depend only on R and C.

Decomposition:
- Shared package holds the op-code localparams: OP_HOLD, OP_LOAD, OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_INC, OP_DEC.
- One natural sub-module: sc_reg_multimode_shifter. It is a combinational barrel shifter computing the next value and carry for SHL/SHR/SAR/ROL.
- The top level holds the next-state mux, INC/DEC, the state register and the flags.

Test Plan:
- Reset async: assert reset between edges with R = 0xDEADBEEF → DataBUS_Out = 0x00000000, Carry = 0, Zero = 1 before the next edge.
- LOAD then HOLD: load 0x80000001, then Write=0 with Op=SHL → value stays 0x80000001, Negative = 1, Carry = 0.
- Shifts from 0x80000001:
  - SHL n=1 → 0x00000002, C = 1.
  - SAR n=4 from 0x80000001 → 0xF8000000, C = 0.
  - SHR n=31 from 0x80000001 → 0x00000001, C = 0.
  - ROL n=4 from 0x80000001 → 0x00000018, C = 0.
- Wrap-around:
  - INC from 0xFFFFFFFF → 0x00000000, C = 1, Zero = 1.
  - DEC from 0x00000000 → 0xFFFFFFFF, C = 1.
  - INC from 0x00000005 → 0x00000006, C = 0.
- Priority: Clear=1 with Write=1, Op=LOAD, Data=0x12345678 → R = 0x00000000, C = 0. Reset asserted the same cycle as Clear → R = 0 asynchronously.
- Parameter sweep: DATAWIDTH_BUS=8 and 12 benches with random ops against a reference model. Cover n = 0 and n ≥ W cases for W=12.
